// File: rtl/match_window_counter_pkg.sv
// Shared types and helpers for the match window counter.
package match_window_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // All-ones value of a count field of the given width (width < 32).
    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/window_bit_counter.sv
// Counts strobed bits within one window; wraps to zero after the last bit.
module window_bit_counter #(
    parameter int WINDOW_LEN = 16
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic count_enable,
    output logic rollover
);

    localparam int BW = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
    localparam logic [BW-1:0] LAST = BW'(WINDOW_LEN - 1);

    logic [BW-1:0] bit_cnt;

    // Bit position counter; clear has priority over counting.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt <= '0;
        end else if (clear) begin
            bit_cnt <= '0;
        end else if (count_enable) begin
            if (bit_cnt == LAST) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign rollover = (bit_cnt == LAST);

endmodule

// File: rtl/match_window_counter.sv
// Counts detector matches over fixed windows of strobed bits and presents
// each window's count on a valid/ready port with saturation and overrun flags.
//
// state | meaning
// IDLE  | not counting; strobes ignored, a pending result may still drain
// RUN   | counting strobed bits and matches, windows back-to-back
module match_window_counter
    import match_window_pkg::*;
#(
    parameter int WINDOW_LEN = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 bit_strobe,
    input  logic                 match,
    input  logic                 count_ready,
    output logic [CNT_WIDTH-1:0] count_data,
    output logic                 count_valid,
    output logic                 overflow,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));

    state_t               state;
    logic [CNT_WIDTH-1:0] match_cnt;
    logic                 sat;
    logic                 rollover;

    logic                 run;
    logic                 strobe_en;
    logic                 at_max;
    logic                 inc_sat;
    logic [CNT_WIDTH-1:0] next_cnt;
    logic                 slot_free;

    assign run       = (state == RUN);
    // Stop and start both take precedence over a strobe in the same cycle.
    assign strobe_en = run & ~stop & ~start & bit_strobe;
    assign at_max    = (match_cnt == CNT_MAX);
    assign inc_sat   = match & at_max;
    assign next_cnt  = (match & ~at_max) ? match_cnt + 1'b1 : match_cnt;
    assign slot_free = ~count_valid | count_ready;

    window_bit_counter #(
        .WINDOW_LEN(WINDOW_LEN)
    ) u_bit_counter (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (start | stop),
        .count_enable(strobe_en),
        .rollover    (rollover)
    );

    // FSM, match accumulation and output slot with registered flags.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            match_cnt   <= '0;
            sat         <= 1'b0;
            count_data  <= '0;
            count_valid <= 1'b0;
            overflow    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (count_valid && count_ready) begin
                count_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        match_cnt <= '0;
                        sat       <= 1'b0;
                        overrun   <= 1'b0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        match_cnt <= '0;
                        sat       <= 1'b0;
                    end else if (start) begin
                        match_cnt <= '0;
                        sat       <= 1'b0;
                        overrun   <= 1'b0;
                    end else if (bit_strobe) begin
                        if (rollover) begin
                            match_cnt <= '0;
                            sat       <= 1'b0;
                            if (slot_free) begin
                                count_data  <= next_cnt;
                                overflow    <= sat | inc_sat;
                                count_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            match_cnt <= next_cnt;
                            sat       <= sat | inc_sat;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/match_window_counter.md
Name: match_window_counter

Overview:
Downstream consumer of the serial "1101" Mealy sequence detector. Samples the detector's match output on each valid bit and counts matches over a fixed window of WINDOW_LEN bits. Presents each window's count on a valid/ready output port, with saturation and overrun reporting. Counting is back-to-back: the next window starts on the cycle after the previous one closes.

Parameters:
WINDOW_LEN, 16, number of strobed bits per window (>=2)
CNT_WIDTH, 8, width of the match count; the count saturates at 2^CNT_WIDTH-1

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
start  in  1  pulse: begin or restart counting; clears overrun
stop  in  1  pulse: abort counting and return to idle
bit_strobe  in  1  a detector bit was evaluated this cycle
match  in  1  detector output o; meaningful only when bit_strobe=1
count_ready  in  1  consumer accepts count_data
count_data  out  CNT_WIDTH  match count of the last completed window
count_valid  out  1  count_data holds an unaccepted result
overflow  out  1  count_data saturated; qualified by count_valid
overrun  out  1  sticky: a completed window was dropped
busy  out  1  state is RUN

Behaviour:
- Reset (async, n_rst=0): state IDLE; bit_cnt=0, match_cnt=0, sat=0; all outputs 0. Reset mid-window discards everything.
- States: IDLE, RUN. busy is a registered decode of the state.
- IDLE:
  - start=1 -> RUN; clear bit_cnt, match_cnt, sat, overrun.
  - bit_strobe and match are ignored.
- RUN, priority order:
  - stop=1 -> IDLE. Partial window is discarded. A pending output is kept. stop wins over start.
  - start=1 -> stay in RUN; clear bit_cnt, match_cnt, sat, overrun. Strobe in the same cycle is ignored.
  - bit_strobe=1 -> bit_cnt+1.
    - If match=1, match_cnt+1 saturating at max; an increment attempted at max sets sat.
  - match with bit_strobe=0 has no effect.
- Window close: bit_strobe=1 with bit_cnt==WINDOW_LEN-1.
  - Final value = match_cnt plus this cycle's match, saturating; flag = sat OR (this increment saturated).
  - At that edge, bit_cnt, match_cnt and sat clear to 0, and the state stays RUN.
  - If the output slot is free (count_valid=0, or count_valid&count_ready this edge): count_data<=final, overflow<=flag, count_valid<=1.
  - Otherwise the old data is retained, the new result is dropped, and overrun<=1.
- Latency: count_valid rises one clock after the edge that samples the last strobe.
- Output handshake:
  - count_data and overflow are stable while count_valid=1.
  - A transfer occurs at a rising edge with count_valid&count_ready.
  - count_valid falls after a transfer unless a window closes on the same edge, in which case it stays 1 with the new data.
  - count_ready while count_valid=0 is ignored.
- overrun is cleared only by start or reset.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package match_window_pkg:
  - state enum typedef {IDLE, RUN}.
  - Helper constant CNT_MAX = 2^CNT_WIDTH-1 (computed locally from the parameter).
- Sub-module window_bit_counter: parameterised rollover counter.
  - Inputs: clear, count_enable (bit_strobe in RUN).
  - Output: a rollover flag asserted when the count equals WINDOW_LEN-1.
  - Instantiated once.
- Match accumulation, output slot and FSM live in the top module.

Test Plan:
1. Reset: drive n_rst=0 mid-window, off the clock edge -> all outputs 0 immediately; busy=0 and count_valid=0 after release.
2. WINDOW_LEN=8, CNT_WIDTH=8: start, 8 consecutive strobes with match=1 on strobes 3 and 6, count_ready=1 -> count_valid=1 for one cycle, one clock after the 8th strobe edge; count_data=2, overflow=0.
3. WINDOW_LEN=20, CNT_WIDTH=4: start, 20 strobes all match=1 -> count_data=15, overflow=1; 5 strobes with match=1 and bit_strobe=0 interleaved do not change the result.
4. WINDOW_LEN=8: count_ready=0 across two windows (matches 1, then 4) -> count_data=1 held, overrun=1; raise count_ready -> count_valid falls next cycle; a later start clears overrun.
5. WINDOW_LEN=8: count_ready=1 on the exact edge where window 2 closes (window 1 count=3, window 2 count=5) -> count_valid stays 1, count_data=5, overrun=0.
6. stop after 5 of 8 strobes, then start, then 8 strobes with 1 match -> no output for the partial window; count_data=1; stop+start asserted together -> IDLE.
